// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its share arbiter: op codes, widths and
// arbiter state encoding.
package alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 3;

  localparam logic [OP_WIDTH-1:0] ALU_AND = 3'b000;
  localparam logic [OP_WIDTH-1:0] ALU_OR  = 3'b001;
  localparam logic [OP_WIDTH-1:0] ALU_NOR = 3'b010;
  localparam logic [OP_WIDTH-1:0] ALU_ADD = 3'b011;
  localparam logic [OP_WIDTH-1:0] ALU_SUB = 3'b100;
  localparam logic [OP_WIDTH-1:0] ALU_LUI = 3'b101;
  localparam logic [OP_WIDTH-1:0] ALU_JAL = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side handshake bundle of the ALU share arbiter.
// master = requesters, slave = arbiter.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [OP_WIDTH-1:0]   req_op0;
  logic [OP_WIDTH-1:0]   req_op1;
  logic [DATA_WIDTH-1:0] req_a0;
  logic [DATA_WIDTH-1:0] req_a1;
  logic [DATA_WIDTH-1:0] req_b0;
  logic [DATA_WIDTH-1:0] req_b1;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_zero;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; combinational, the pointer lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |valid;
    gnt_idx   = 1'b0;
    case (valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_ptr;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one operation at a time.
// Optional ALU_SHARE_ARB_STATS_EN adds saturating per-requester grant counters.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready offered to the grant winner
// EXEC    | ALU evaluated from the operand registers
// RESP    | result held for the owner until it is consumed
module alu_share_arbiter #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int OP_WIDTH   = alu_pkg::OP_WIDTH
`ifdef ALU_SHARE_ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_share_arbiter_if.slave    bus,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
`ifdef ALU_SHARE_ARB_STATS_EN
  , output logic [CNT_WIDTH-1:0] grant_cnt0
  , output logic [CNT_WIDTH-1:0] grant_cnt1
`endif
);
  import alu_pkg::*;

  arb_state_t            state;
  logic                  rr_ptr;
  logic                  owner;
  logic [OP_WIDTH-1:0]   op_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  zero_r;
  logic [1:0]            rsp_valid_r;

  logic                  gnt_valid;
  logic                  gnt_idx;
  logic                  accept;
  logic [OP_WIDTH-1:0]   op_sel;
  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel;

  rr_arbiter2 u_rr (
    .valid     (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign accept        = (state == ST_IDLE) && gnt_valid;
  assign bus.req_ready = accept ? onehot2(gnt_idx) : 2'b00;

  assign op_sel = gnt_idx ? bus.req_op1 : bus.req_op0;
  assign a_sel  = gnt_idx ? bus.req_a1  : bus.req_a0;
  assign b_sel  = gnt_idx ? bus.req_b1  : bus.req_b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      result_r    <= '0;
      zero_r      <= 1'b0;
      rsp_valid_r <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= gnt_idx;
            op_r  <= op_sel;
            a_r   <= a_sel;
            b_r   <= b_sel;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_r    <= alu_result;
          zero_r      <= alu_zero;
          rsp_valid_r <= onehot2(owner);
          state       <= ST_RESP;
        end
        ST_RESP: begin
          // the pointer moves only when a response completes
          if (bus.rsp_ready[owner]) begin
            rsp_valid_r <= 2'b00;
            rr_ptr      <= ~owner;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_op         = op_r;
  assign alu_a          = a_r;
  assign alu_b          = b_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = result_r;
  assign bus.rsp_zero   = zero_r;

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (gnt_idx) begin
        if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
      end else begin
        if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU and a
// transaction-level model of grant order, latency and results.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [1:0]  grant_cnt0;
  logic [1:0]  grant_cnt1;
`endif

  int   tests = 0;
  int   fails = 0;
  logic m_ptr;
  int   m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(
    .DATA_WIDTH (32),
    .OP_WIDTH   (3)
`ifdef ALU_SHARE_ARB_STATS_EN
    , .CNT_WIDTH (2)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
`ifdef ALU_SHARE_ARB_STATS_EN
    , .grant_cnt0 (grant_cnt0)
    , .grant_cnt1 (grant_cnt1)
`endif
  );

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOR: return ~(a | b);
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_LUI: return {b[15:0], 16'h0000};
      ALU_JAL: return a + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  task automatic set_req(input logic r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (r) begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end else begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req(1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1'b1, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_ptr  = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
  endtask

  // Called in an IDLE cycle before its rising edge; returns at the negedge of
  // the IDLE cycle that follows the completed response, with valids cleared.
  task automatic run_op(input logic [1:0] vmask, input int hold, input bit keep,
                        output logic g);
    logic [1:0]  oh;
    logic [31:0] er;
    logic        ez;
    logic [31:0] rnd;
    g  = (vmask == 2'b11) ? m_ptr : vmask[1];
    oh = g ? 2'b10 : 2'b01;
    bus.req_valid = vmask;
    #1;
    tests++;
    if (bus.req_ready !== oh) begin
      fails++;
      $display("FAIL grant: req_ready got %b want %b (valid %b)", bus.req_ready, oh, vmask);
    end
    er = g ? alu_ref(bus.req_op1, bus.req_a1, bus.req_b1)
           : alu_ref(bus.req_op0, bus.req_a0, bus.req_b0);
    ez = (er == 32'd0);
    if (g) m_cnt1++; else m_cnt0++;
    @(posedge clk); #1;
    if (keep) begin
      rnd = $urandom;
      set_req(g, g ? bus.req_op1 : bus.req_op0, rnd, ~rnd);
    end else begin
      bus.req_valid[g] = 1'b0;
    end
    @(negedge clk);
    tests++;
    if ({bus.rsp_valid, bus.req_ready} !== 4'b0000) begin
      fails++;
      $display("FAIL exec_idle: rsp_valid/req_ready got %b/%b want 00/00",
               bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== oh || bus.rsp_result !== er || bus.rsp_zero !== ez) begin
      fails++;
      $display("FAIL response: got v=%b r=%h z=%b want v=%b r=%h z=%b",
               bus.rsp_valid, bus.rsp_result, bus.rsp_zero, oh, er, ez);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.rsp_ready = ~oh;
      bus.req_valid = 2'b11;
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== oh || bus.rsp_result !== er || bus.rsp_zero !== ez ||
          bus.req_ready !== 2'b00) begin
        fails++;
        $display("FAIL hold: got v=%b r=%h z=%b rdy=%b want v=%b r=%h z=%b rdy=00",
                 bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.req_ready, oh, er, ez);
      end
    end
    @(posedge clk); #1;
    bus.rsp_ready = oh;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b00;
    m_ptr = ~g;
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL release: rsp_valid got %b want 00", bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd0 ||
        bus.rsp_zero !== 1'b0 || alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b v=%b r=%h z=%b op=%h a=%h b=%h want all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, alu_op, alu_a, alu_b);
    end
  endtask

  task automatic test_single();
    logic g;
    set_req(1'b0, ALU_ADD, 32'd5, 32'd7);
    run_op(2'b01, 0, 1'b0, g);
  endtask

  task automatic test_zero_flag();
    logic g;
    set_req(1'b1, ALU_SUB, 32'h1234, 32'h1234);
    run_op(2'b10, 0, 1'b0, g);
  endtask

  task automatic test_fairness();
    logic g;
    do_reset();
    set_req(1'b0, ALU_AND, 32'hF0F0_1234, 32'hFF00_FFFF);
    set_req(1'b1, ALU_AND, 32'h0F0F_ABCD, 32'h00FF_FFFF);
    for (int i = 0; i < 8; i++) run_op(2'b11, 0, 1'b1, g);
  endtask

  task automatic test_backpressure();
    logic g;
    set_req(1'b0, ALU_OR, 32'h0000_00A0, 32'h0000_000B);
    run_op(2'b01, 5, 1'b0, g);
  endtask

  task automatic test_reset_midop();
    logic g;
    set_req(1'b0, ALU_ADD, 32'd1, 32'd2);
    run_op(2'b01, 0, 1'b0, g);
    set_req(1'b0, ALU_NOR, 32'h1357_9BDF, 32'h0246_8ACE);
    bus.req_valid = 2'b01;
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL midop_accept: req_ready got %b want 01", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_result !== 32'd0 ||
        alu_op !== 3'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      fails++;
      $display("FAIL midop_reset: rdy=%b v=%b r=%h op=%h a=%h b=%h want all zero",
               bus.req_ready, bus.rsp_valid, bus.rsp_result, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    reset  = 1'b0;
    m_ptr  = 1'b0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rsp_valid !== 2'b00) begin
        fails++;
        $display("FAIL midop_no_rsp: rsp_valid got %b want 00", bus.rsp_valid);
      end
    end
    bus.req_valid = 2'b11;
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL midop_ptr: req_ready got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_random();
    logic        g;
    logic [31:0] r, a0, a1, b1;
    logic [1:0]  vm;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom;
      a0 = $urandom;
      a1 = $urandom;
      b1 = r[8] ? a1 : $urandom;
      vm = r[1:0];
      if (vm == 2'b00) vm = 2'b11;
      set_req(1'b0, r[12:10], a0, r[9] ? a0 : $urandom);
      set_req(1'b1, r[15:13], a1, b1);
      run_op(vm, int'(r[3:2]), r[4], g);
    end
  endtask

`ifdef ALU_SHARE_ARB_STATS_EN
  task automatic test_stats();
    logic       g;
    logic [1:0] e0, e1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b0, ALU_ADD, $urandom, $urandom);
      run_op(2'b01, 0, 1'b0, g);
    end
    e0 = (m_cnt0 > 3) ? 2'd3 : 2'(m_cnt0);
    e1 = (m_cnt1 > 3) ? 2'd3 : 2'(m_cnt1);
    tests++;
    if (grant_cnt0 !== e0 || grant_cnt1 !== e1) begin
      fails++;
      $display("FAIL stats: cnt0/cnt1 got %0d/%0d want %0d/%0d", grant_cnt0, grant_cnt1, e0, e1);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    test_random();
`ifdef ALU_SHARE_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
